// File: rtl/apb_completer_regbank.sv
// APB3/APB4 completer: NUM_REGS byte-writable scratch registers followed by a
// read-only ID word. Inserts WAIT_STATES PREADY-low cycles per access phase and
// reports illegal accesses with PSLVERR. Address/control are decoded once in
// the setup cycle; PWDATA/PSTRB are sampled at the completion edge.
module apb_completer_regbank #(
  parameter int          ADDRWIDTH   = 16,
  parameter int          DATAWIDTH   = 32,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h4150_4231,
  parameter bit          PRIV_ONLY   = 1'b0
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic                 PWRITE,
  input  logic [DATAWIDTH-1:0] PWDATA,
  input  logic [3:0]           PSTRB,
  input  logic [2:0]           PPROT,
  output logic [DATAWIDTH-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR
);

  localparam int CNTW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int IDXW = ADDRWIDTH - 2;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(WAIT_STATES);
  localparam logic [IDXW-1:0] ID_IDX   = IDXW'(NUM_REGS);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   wr_q, wr_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic [DATAWIDTH-1:0]   rdata_q, rdata_d;
  logic [DATAWIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATAWIDTH-1:0]   regs_d [NUM_REGS];

  logic [IDXW-1:0]        addr_idx_s;
  logic                   setup_s;
  logic                   violation_s;
  logic                   complete_s;
  logic                   commit_s;
  logic                   dec_err_s;
  logic [DATAWIDTH-1:0]   dec_rdata_s;
  logic                   unused_pprot_s;

  // Merge new bytes into an old word lane by lane under a strobe mask.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

  assign addr_idx_s     = PADDR[ADDRWIDTH-1:2];
  assign setup_s        = PSEL & ~PENABLE;
  assign violation_s    = (state_q == ST_IDLE) & PSEL & PENABLE;
  assign complete_s     = (state_q == ST_ACCESS) & PSEL & (cnt_q == {CNTW{1'b0}});
  assign commit_s       = complete_s & wr_q & ~err_q;
  assign unused_pprot_s = ^PPROT[2:1];

  // Decode the setup-cycle address into an error flag and the read word.
  always_comb begin
    dec_err_s   = 1'b0;
    dec_rdata_s = '0;
    if (PADDR[1:0] != 2'b00) begin
      dec_err_s = 1'b1;
    end else if (addr_idx_s > ID_IDX) begin
      dec_err_s = 1'b1;
    end else if (PWRITE && (addr_idx_s == ID_IDX)) begin
      dec_err_s = 1'b1;
    end else if (PRIV_ONLY && !PPROT[0]) begin
      dec_err_s = 1'b1;
    end else begin
      dec_err_s = 1'b0;
    end
    if (!dec_err_s && !PWRITE) begin
      if (addr_idx_s == ID_IDX) begin
        dec_rdata_s = ID_VALUE;
      end else begin
        for (int i = 0; i < NUM_REGS; i++) begin
          dec_rdata_s = dec_rdata_s | (regs_q[i] & {DATAWIDTH{addr_idx_s == IDXW'(i)}});
        end
      end
    end else begin
      dec_rdata_s = '0;
    end
  end

  // Transfer FSM: setup latches the decode, access counts down the wait states.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (setup_s) begin
          state_d = ST_ACCESS;
          cnt_d   = CNT_LOAD;
          err_d   = dec_err_s;
          wr_d    = PWRITE;
          idx_d   = addr_idx_s;
          rdata_d = dec_rdata_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (cnt_q != {CNTW{1'b0}}) begin
          cnt_d = cnt_q - {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register-bank next state: byte-merge on a legal write completion only.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = merge_bytes(regs_q[i], PWDATA,
                              PSTRB & {4{commit_s && (idx_q == IDXW'(i))}});
    end
  end

  // State, latched decode and register bank with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      rdata_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Outputs are forced quiet while reset is held; a missing setup cycle is
  // answered immediately with an error so the requester is never stalled.
  assign PREADY  = ~PRESET & (complete_s | violation_s);
  assign PSLVERR = ~PRESET & ((complete_s & err_q) | violation_s);
  assign PRDATA  = (~PRESET & complete_s & ~wr_q) ? rdata_q : '0;

endmodule
